store_buffer: RTL

- FIFO write buffer between the pipeline M stage and the data memory's write port.
- Decouples store retirement from the memory write: a store is accepted in one cycle and later drained to memory, at most one per cycle, in program order.
- Detects a load that reads a word still pending in the buffer and stalls the M stage until that word has drained.
- Drives the data memory's memwrite / memaddr / dmi / dmictr inputs directly, plus the store's PC for the memory's write log.

---
 rtl/store_buffer_pkg.sv | 17 +
 rtl/store_buffer_if.sv | 36 +++
 rtl/store_buffer_fifo.sv | 69 ++++++
 rtl/store_buffer.sv | 72 +++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer, data memory and controller:
// store width codes and the layout of one buffered store.
package store_buffer_pkg;

    localparam logic [1:0] DM_SW = 2'b00;
    localparam logic [1:0] DM_SH = 2'b01;
    localparam logic [1:0] DM_SB = 2'b11;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  ctr;
        logic [31:0] data;
        logic [31:0] addr;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// M-stage / data-memory side signals of the store buffer.
// The master is the pipeline and memory side. The slave is the buffer.
interface store_buffer_if #(
    parameter int DEPTH = 4
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [1:0]    st_ctr;
    logic [31:0]   st_pc;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic          drain_en;
    logic          stall;
    logic          memwrite;
    logic [31:0]   memaddr;
    logic [31:0]   dmi;
    logic [1:0]    dmictr;
    logic [31:0]   dm_pc;
    logic [CW-1:0] count;
    logic          empty;

    modport master (
        output st_valid, st_addr, st_data, st_ctr, st_pc, ld_valid, ld_addr, drain_en,
        input  stall, memwrite, memaddr, dmi, dmictr, dm_pc, count, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_ctr, st_pc, ld_valid, ld_addr, drain_en,
        output stall, memwrite, memaddr, dmi, dmictr, dm_pc, count, empty
    );

endinterface

// File: rtl/store_buffer_fifo.sv
// In-order entry storage for the store buffer.
// All entries are exposed so the parent can run the load-hazard compare in parallel.
module store_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  sb_entry_t                   push_entry,
    input  logic                        pop,
    output sb_entry_t                   head,
    output sb_entry_t [DEPTH-1:0]       entries,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        // Head and tail alias only when empty or full, so push and pop never hit the same slot.
        if (do_push) begin
            mem_d[tail_q]       = push_entry;
            mem_d[tail_q].valid = 1'b1;
            tail_d              = tail_q + 1'b1;
        end
        if (do_pop) begin
            mem_d[head_q].valid = 1'b0;
            head_d              = head_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head    = mem_q[head_q];
    assign entries = mem_q;
    assign count   = count_q;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the M stage and the data memory write port: accepts stores,
// drains them in order, and stalls loads that read a word still pending.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave bus
);

    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t             head;
    sb_entry_t             push_entry;
    logic                  full, empty;
    logic                  push, pop;
    logic                  ld_req, hit;
    logic                  unused_ld_bits;

    assign push = bus.st_valid && !full;
    assign pop  = bus.drain_en && !empty;

    always_comb begin
        push_entry       = '0;
        push_entry.valid = 1'b1;
        push_entry.addr  = bus.st_addr;
        push_entry.data  = bus.st_data;
        push_entry.pc    = bus.st_pc;
        // The unused 2'b10 code is folded onto DM_SB so memory only ever sees legal codes.
        push_entry.ctr   = (bus.st_ctr == 2'b10) ? DM_SB : bus.st_ctr;
    end

    store_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .entries    (entries),
        .count      (bus.count),
        .full       (full),
        .empty      (empty)
    );

    // A store and a load in the same cycle are treated as a store only.
    assign ld_req = bus.ld_valid && !bus.st_valid;

    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && (entries[i].addr[AW-1:2] == bus.ld_addr[AW-1:2]))
                hit = 1'b1;
        end
        hit = hit && ld_req;
    end

    assign unused_ld_bits = ^{bus.ld_addr[31:AW], bus.ld_addr[1:0]};

    assign bus.stall    = (bus.st_valid && full) || hit;
    assign bus.memwrite = pop;
    assign bus.memaddr  = empty ? '0 : head.addr;
    assign bus.dmi      = empty ? '0 : head.data;
    assign bus.dmictr   = empty ? '0 : head.ctr;
    assign bus.dm_pc    = empty ? '0 : head.pc;
    assign bus.empty    = empty;

endmodule
